// File: rtl/neurex_sched_pkg.sv
// Shared types and constants for the neurex GEMM tile scheduler.
package neurex_sched_pkg;

  localparam int unsigned DIM_W = 16;

  typedef logic [DIM_W-1:0] dim_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    WRITE,
    DONE
  } sched_state_e;

  // Cycles for the last operand to ripple out of a rows x cols systolic array.
  function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sched_wrap_cnt.sv
// Enable-gated up-counter that wraps to zero after reaching a programmable limit.
module sched_wrap_cnt
  import neurex_sched_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == limit);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/neurex_tile_sched.sv
// GEMM tile scheduler: walks output tiles, streams the common dimension, drains and commits rows.
// Optional build macro NEUREX_SCHED_PERF_EN adds saturating perf_cycles/perf_stalls counters.
module neurex_tile_sched
  import neurex_sched_pkg::*;
#(
  parameter int unsigned SYS_ROW    = 4,
  parameter int unsigned SYS_COL    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ACCUM_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] num_in,
  input  logic [DATA_WIDTH-1:0] num_common,
  input  logic [DATA_WIDTH-1:0] num_out,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  in_rd_en,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] in_rd_addr,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  output logic                  acc_wr_en,
  output logic [ADDR_WIDTH-1:0] acc_addr
`ifdef NEUREX_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls
`endif
);

  localparam int unsigned DRN = drain_len(SYS_ROW, SYS_COL);
  localparam int unsigned PW  = 2 * DATA_WIDTH + 34;

  sched_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] nc_q, nc_d, mt_q, mt_d, nt_q, nt_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  in_rd_en_q, in_rd_en_d, w_rd_en_q, w_rd_en_d, acc_wr_en_q, acc_wr_en_d;
  logic [ADDR_WIDTH-1:0] in_rd_addr_q, in_rd_addr_d, w_rd_addr_q, w_rd_addr_d;
  logic [ADDR_WIDTH-1:0] acc_addr_q, acc_addr_d;

  logic [DATA_WIDTH:0]   mt_w, nt_w;
  logic [PW-1:0]         rows_w;
  logic                  cfg_bad;
  logic                  accept, load_go;

  logic [DATA_WIDTH-1:0] k_cnt, d_cnt, r_cnt, n_cnt, m_cnt;
  logic                  k_last, d_last, r_last, n_last, m_last;
  logic [ADDR_WIDTH-1:0] tile_idx;

  // Tile counts and accumulator footprint of the requested config, evaluated at start.
  always_comb begin
    mt_w    = ({1'b0, num_in} + (DATA_WIDTH+1)'(SYS_ROW - 1)) / (DATA_WIDTH+1)'(SYS_ROW);
    nt_w    = ({1'b0, num_out} + (DATA_WIDTH+1)'(SYS_COL - 1)) / (DATA_WIDTH+1)'(SYS_COL);
    rows_w  = PW'(mt_w) * PW'(nt_w) * PW'(SYS_ROW);
    cfg_bad = (num_in == '0) || (num_common == '0) || (num_out == '0) ||
              (rows_w > PW'(ACCUM_SIZE));
  end

  assign accept  = (state_q == IDLE) && start;
  assign load_go = (state_q == LOAD) && !stall;

  sched_wrap_cnt #(.W(DATA_WIDTH)) u_k_cnt (
    .clk(clk), .rstn(rstn), .clr(accept), .en(load_go),
    .limit(nc_q - DATA_WIDTH'(1)), .cnt(k_cnt), .last(k_last)
  );

  sched_wrap_cnt #(.W(DATA_WIDTH)) u_d_cnt (
    .clk(clk), .rstn(rstn), .clr(accept), .en(state_q == DRAIN),
    .limit(DATA_WIDTH'(DRN - 1)), .cnt(d_cnt), .last(d_last)
  );

  sched_wrap_cnt #(.W(DATA_WIDTH)) u_r_cnt (
    .clk(clk), .rstn(rstn), .clr(accept), .en(state_q == WRITE),
    .limit(DATA_WIDTH'(SYS_ROW - 1)), .cnt(r_cnt), .last(r_last)
  );

  sched_wrap_cnt #(.W(DATA_WIDTH)) u_n_cnt (
    .clk(clk), .rstn(rstn), .clr(accept), .en((state_q == WRITE) && r_last),
    .limit(nt_q - DATA_WIDTH'(1)), .cnt(n_cnt), .last(n_last)
  );

  sched_wrap_cnt #(.W(DATA_WIDTH)) u_m_cnt (
    .clk(clk), .rstn(rstn), .clr(accept), .en((state_q == WRITE) && r_last && n_last),
    .limit(mt_q - DATA_WIDTH'(1)), .cnt(m_cnt), .last(m_last)
  );

  always_comb begin
    if (state_q == DRAIN) begin
      assert (d_cnt < DATA_WIDTH'(DRN));
    end
  end

  always_comb begin
    state_d   = state_q;
    nc_d      = nc_q;
    mt_d      = mt_q;
    nt_d      = nt_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          nc_d      = num_common;
          mt_d      = mt_w[DATA_WIDTH-1:0];
          nt_d      = nt_w[DATA_WIDTH-1:0];
          cfg_err_d = cfg_bad;
          state_d   = cfg_bad ? DONE : LOAD;
        end
      end
      LOAD:  if (load_go && k_last) state_d = DRAIN;
      DRAIN: if (d_last) state_d = WRITE;
      WRITE: if (r_last) state_d = (m_last && n_last) ? DONE : LOAD;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current state/counters, so they trail the state by one edge.
  always_comb begin
    tile_idx     = ADDR_WIDTH'(m_cnt) * ADDR_WIDTH'(nt_q) + ADDR_WIDTH'(n_cnt);
    busy_d       = (state_q != IDLE);
    done_d       = (state_q == DONE);
    err_d        = (state_q == DONE) && cfg_err_q;
    in_rd_en_d   = load_go;
    w_rd_en_d    = load_go;
    in_rd_addr_d = '0;
    w_rd_addr_d  = '0;
    acc_wr_en_d  = (state_q == WRITE);
    acc_addr_d   = '0;
    if (load_go) begin
      in_rd_addr_d = ADDR_WIDTH'(m_cnt) * ADDR_WIDTH'(nc_q) + ADDR_WIDTH'(k_cnt);
      w_rd_addr_d  = ADDR_WIDTH'(n_cnt) * ADDR_WIDTH'(nc_q) + ADDR_WIDTH'(k_cnt);
    end
    if (state_q == WRITE) begin
      acc_addr_d = tile_idx * ADDR_WIDTH'(SYS_ROW) + ADDR_WIDTH'(r_cnt);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      nc_q         <= '0;
      mt_q         <= '0;
      nt_q         <= '0;
      cfg_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      in_rd_en_q   <= 1'b0;
      w_rd_en_q    <= 1'b0;
      in_rd_addr_q <= '0;
      w_rd_addr_q  <= '0;
      acc_wr_en_q  <= 1'b0;
      acc_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      nc_q         <= nc_d;
      mt_q         <= mt_d;
      nt_q         <= nt_d;
      cfg_err_q    <= cfg_err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      in_rd_en_q   <= in_rd_en_d;
      w_rd_en_q    <= w_rd_en_d;
      in_rd_addr_q <= in_rd_addr_d;
      w_rd_addr_q  <= w_rd_addr_d;
      acc_wr_en_q  <= acc_wr_en_d;
      acc_addr_q   <= acc_addr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign in_rd_en   = in_rd_en_q;
  assign w_rd_en    = w_rd_en_q;
  assign in_rd_addr = in_rd_addr_q;
  assign w_rd_addr  = w_rd_addr_q;
  assign acc_wr_en  = acc_wr_en_q;
  assign acc_addr   = acc_addr_q;

`ifdef NEUREX_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (accept) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (busy_d && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == LOAD) && stall && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_neurex_tile_sched.sv
// Self-checking bench for neurex_tile_sched: hand-computed vector table, directed corner
// sequences and randomized configs/stalls against a per-cycle schedule model.
module tb_neurex_tile_sched;

  localparam int SR   = 4;
  localparam int SC   = 4;
  localparam int DRN  = SR + SC - 1;
  localparam int ACC  = 32;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  neurex_sched_pkg::dim_t num_in = '0, num_common = '0, num_out = '0;
  logic        busy, done, err, in_rd_en, w_rd_en, acc_wr_en;
  logic [15:0] in_rd_addr, w_rd_addr, acc_addr;
`ifdef NEUREX_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  neurex_tile_sched #(
    .SYS_ROW(SR), .SYS_COL(SC), .DATA_WIDTH(16), .ADDR_WIDTH(16), .ACCUM_SIZE(ACC)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .num_in(num_in), .num_common(num_common), .num_out(num_out),
    .stall(stall), .busy(busy), .done(done), .err(err),
    .in_rd_en(in_rd_en), .w_rd_en(w_rd_en),
    .in_rd_addr(in_rd_addr), .w_rd_addr(w_rd_addr),
    .acc_wr_en(acc_wr_en), .acc_addr(acc_addr)
`ifdef NEUREX_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        in_en;
    logic        w_en;
    logic [15:0] in_a;
    logic [15:0] w_a;
    logic        acc_en;
    logic [15:0] acc_a;
  } obs_t;

  typedef struct {
    int ni;
    int nc;
    int no;
    int exp_done;
    bit exp_err;
  } vec_t;

  obs_t exp_a    [0:MAXC];
  bit   stall_at [0:MAXC+1];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm, input int cyc, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0d: got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  function automatic obs_t raw_obs();
    obs_t o;
    o = '{busy, done, err, in_rd_en, w_rd_en, in_rd_addr, w_rd_addr, acc_wr_en, acc_addr};
    return o;
  endfunction

  // Addresses are only meaningful alongside their strobe; err only alongside done.
  function automatic obs_t sample();
    obs_t o;
    o = raw_obs();
    if (!o.in_en)  o.in_a  = '0;
    if (!o.w_en)   o.w_a   = '0;
    if (!o.acc_en) o.acc_a = '0;
    if (!o.done)   o.err   = 1'b0;
    return o;
  endfunction

  // Expected timeline: cycle 1 is the first cycle after the edge that samples start.
  task automatic build_model(input int ni, input int nc, input int no, output int d, output int nst);
    int mt, nt, t;
    for (int i = 0; i <= MAXC; i++) exp_a[i] = '0;
    mt  = (ni + SR - 1) / SR;
    nt  = (no + SC - 1) / SC;
    nst = 0;
    if (ni == 0 || nc == 0 || no == 0 || mt * nt * SR > ACC) begin
      exp_a[1].busy = 1'b1;
      exp_a[1].done = 1'b1;
      exp_a[1].err  = 1'b1;
      d = 1;
      return;
    end
    t = 1;
    for (int m = 0; m < mt; m++) begin
      for (int n = 0; n < nt; n++) begin
        for (int k = 0; k < nc; k++) begin
          while (t < MAXC - 64 && stall_at[t]) begin
            exp_a[t].busy = 1'b1;
            nst++;
            t++;
          end
          exp_a[t].busy  = 1'b1;
          exp_a[t].in_en = 1'b1;
          exp_a[t].w_en  = 1'b1;
          exp_a[t].in_a  = 16'(m * nc + k);
          exp_a[t].w_a   = 16'(n * nc + k);
          t++;
        end
        for (int dd = 0; dd < DRN; dd++) begin
          exp_a[t].busy = 1'b1;
          t++;
        end
        for (int r = 0; r < SR; r++) begin
          exp_a[t].busy   = 1'b1;
          exp_a[t].acc_en = 1'b1;
          exp_a[t].acc_a  = 16'((m * nt + n) * SR + r);
          t++;
        end
      end
    end
    exp_a[t].busy = 1'b1;
    exp_a[t].done = 1'b1;
    d = t;
  endtask

  task automatic clear_stalls();
    for (int i = 0; i <= MAXC + 1; i++) stall_at[i] = 1'b0;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_one(input int ni, input int nc, input int no, input bit hold, input int abort_cyc,
                         output int obs_done, output bit obs_err);
    int   d, nst;
    obs_t got;
    build_model(ni, nc, no, d, nst);
    obs_done   = 0;
    obs_err    = 1'b0;
    num_in     = 16'(ni);
    num_common = 16'(nc);
    num_out    = 16'(no);
    start      = 1'b1;
    stall      = stall_at[0];
    @(posedge clk);
    #1;
    if (!hold) begin
      start      = 1'b0;
      num_in     = 16'($urandom);
      num_common = 16'($urandom);
      num_out    = 16'($urandom);
    end
    stall = stall_at[1];
    for (int t = 1; t <= d; t++) begin
      @(posedge clk);
      #1;
      got = sample();
      if (got.done && obs_done == 0) begin
        obs_done = t;
        obs_err  = got.err;
      end
      check("cycle", t, 64'(got), 64'(exp_a[t]));
`ifdef NEUREX_SCHED_PERF_EN
      if (t == d) begin
        check("perf_cycles", t, 64'(perf_cycles), 64'(d));
        check("perf_stalls", t, 64'(perf_stalls), 64'(nst));
      end
`endif
      if (t == abort_cyc) begin
        rstn = 1'b0;
        #1;
        check("rst_async", t, 64'(raw_obs()), 64'(0));
        @(posedge clk);
        #1;
        check("rst_hold", t + 1, 64'(raw_obs()), 64'(0));
        rstn  = 1'b1;
        stall = 1'b0;
        return;
      end
      stall = stall_at[t + 1];
    end
    stall = 1'b0;
  endtask

  vec_t tbl [10];

  initial begin
    int   od;
    bit   oe;
    obs_t g;

    tbl[0] = '{8, 8, 16, 153, 1'b0};
    tbl[1] = '{12, 8, 16, 1, 1'b1};
    tbl[2] = '{4, 0, 4, 1, 1'b1};
    tbl[3] = '{4, 3, 4, 15, 1'b0};
    tbl[4] = '{5, 2, 5, 53, 1'b0};
    tbl[5] = '{0, 4, 4, 1, 1'b1};
    tbl[6] = '{1, 1, 1, 13, 1'b0};
    tbl[7] = '{16, 1, 8, 97, 1'b0};
    tbl[8] = '{17, 1, 4, 61, 1'b0};
    tbl[9] = '{4, 1, 33, 1, 1'b1};

    clear_stalls();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 0, 64'(raw_obs()), 64'(0));
`ifdef NEUREX_SCHED_PERF_EN
    check("reset_perf", 0, {perf_cycles, perf_stalls}, 64'(0));
`endif
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: each entry starts in the cycle after the previous DONE.
    for (int i = 0; i < 10; i++) begin
      clear_stalls();
      run_one(tbl[i].ni, tbl[i].nc, tbl[i].no, 1'b0, 0, od, oe);
      check("tbl_done", i, 64'(od), 64'(tbl[i].exp_done));
      check("tbl_err", i, 64'(oe), 64'(tbl[i].exp_err));
    end

    clear_stalls();
    for (int t = 3; t <= 5; t++) stall_at[t] = 1'b1;
    run_one(8, 8, 16, 1'b0, 0, od, oe);
    check("stall_done", 0, 64'(od), 64'(156));

    clear_stalls();
    run_one(8, 8, 16, 1'b0, 40, od, oe);
    check("abort_no_done", 40, 64'(od), 64'(0));
    @(posedge clk);
    #1;
    g = raw_obs();
    check("post_reset_idle", 0, 64'({g.busy, g.done}), 64'(0));
    run_one(8, 8, 16, 1'b0, 0, od, oe);
    check("restart_done", 0, 64'(od), 64'(153));

    run_one(8, 8, 16, 1'b1, 0, od, oe);
    check("hold_done1", 0, 64'(od), 64'(153));
    run_one(8, 8, 16, 1'b1, 0, od, oe);
    check("hold_done2", 0, 64'(od), 64'(153));
    start = 1'b0;
    @(posedge clk);
    #1;
    check("hold_release_idle", 0, 64'(busy), 64'(0));

    for (int it = 0; it < 25; it++) begin
      int ni, nc, no;
      ni = int'($urandom_range(0, 18));
      nc = int'($urandom_range(0, 8));
      no = int'($urandom_range(0, 18));
      for (int i = 0; i <= MAXC + 1; i++) stall_at[i] = ($urandom_range(0, 3) == 0);
      run_one(ni, nc, no, 1'b0, 0, od, oe);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/neurex_tile_sched.md
# neurex_tile_sched

Tile scheduler that sequences one GEMM (`num_in` × `num_common` × `num_out`) through the SYS_ROW×SYS_COL systolic array of `top_neurex`. It sits between the host/config registers and the input/weight buffers and accumulator. It walks output tiles and, for each tile, streams the common dimension through the array, waits out the pipeline skew and commits the tile's rows to the accumulator. It replaces the hand-driven `in_en`/`w_en` sequencing with address-generating, back-pressure-aware control.

## Interface
Parameters:
- `SYS_ROW`, 4: array rows; rows per output tile.
- `SYS_COL`, 4: array columns; columns per output tile.
- `DATA_WIDTH`, 16: width of the dimension inputs.
- `ADDR_WIDTH`, 16: width of all buffer and accumulator addresses.
- `ACCUM_SIZE`, 32: accumulator depth in rows.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `num_in`, `num_common`, `num_out`  in  DATA_WIDTH each  GEMM dimensions; latched on an accepted `start`.
- `stall`  in  1  downstream FIFO full; freezes LOAD.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  configuration error; valid while `done`=1.
- `in_rd_en`, `w_rd_en`  out  1  input and weight buffer read strobes; drive the array's `in_en`/`w_en`.
- `in_rd_addr`, `w_rd_addr`  out  ADDR_WIDTH  input and weight buffer read addresses.
- `acc_wr_en`  out  1  accumulator write strobe for `out_wr_data`.
- `acc_addr`  out  ADDR_WIDTH  accumulator row address.

## Operation
- Derived values, latched with the config:
  - `MT = ceil(num_in/SYS_ROW)`
  - `NT = ceil(num_out/SYS_COL)`
  - `DRAIN = SYS_ROW+SYS_COL-1`
- Tile order: m outer (0..MT-1), n inner (0..NT-1).
- States: IDLE, LOAD, DRAIN, WRITE, DONE.
- IDLE→LOAD on `start`, when the config is legal.
- IDLE→DONE with `err`=1 on `start` when the config is illegal:
  - any dimension is 0, or
  - `MT*NT*SYS_ROW > ACCUM_SIZE`.
  - No reads or writes are issued in this case.
- LOAD: k counts 0..num_common-1.
  - Each non-stalled cycle: `in_rd_en`=`w_rd_en`=1, `in_rd_addr = m*num_common+k`, `w_rd_addr = n*num_common+k`.
  - `stall`=1: both read enables 0, k holds.
  - After k = num_common-1 is issued → DRAIN.
- DRAIN: counts DRAIN cycles; ignores `stall`; then → WRITE.
- WRITE: r counts 0..SYS_ROW-1.
  - `acc_wr_en`=1, `acc_addr = (m*NT+n)*SYS_ROW + r`.
  - After r = SYS_ROW-1: → LOAD with the next (n, m) tile, or → DONE after the last tile.
- DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored; config inputs are not re-sampled mid-run.
- Address arithmetic is unsigned, truncated to ADDR_WIDTH.
- Rows/columns beyond `num_in`/`num_out` in the last tile are still written; software ignores them.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Counters and state reset to 0/IDLE.
- `start` sampled at edge 0:
  - LOAD first issues at cycle 1.
  - `busy` is 1 from cycle 1 through the DONE cycle inclusive.
- Per tile, without stalls: num_common + DRAIN + SYS_ROW cycles.
- Each stall cycle in LOAD adds exactly one cycle.
- Illegal config: DONE at cycle 1 with `err`=1 and `busy`=1 for that cycle only.
- `rstn` low mid-run: immediate return to IDLE, outputs 0, no `done` pulse.
- A new `start` is accepted in the cycle after DONE.

## Configuration
- `NEUREX_SCHED_PERF_EN` defined:
  - Adds outputs `perf_cycles` (32 b, counts busy cycles) and `perf_stalls` (32 b, counts LOAD cycles with `stall`=1).
  - Both clear on an accepted `start` and hold after DONE.
  - Both saturate at all-ones.
- Macro undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `neurex_sched_pkg` holds:
  - state enum `sched_state_e` (IDLE, LOAD, DRAIN, WRITE, DONE);
  - typedef `dim_t` (logic [DATA_WIDTH-1:0]);
  - the `DRAIN` constant function.
- Sub-module `sched_wrap_cnt`: an enable-gated counter with programmable limit and wrap/last flag, instanced for k, drain, r, n and m.

## Test plan
- num_in=8, num_common=8, num_out=16, 4×4, no stall:
  - 8 tiles × 19 cycles; `done` at cycle 153.
  - 64 read pairs, 32 accumulator writes to addresses 0..31 in order.
  - First tile `w_rd_addr` 0..7; second tile 8..15.
- Same config with `stall`=1 for cycles 3–5: `done` at cycle 156; k holds at 2 while stalled; no read strobes during the stall.
- num_in=12 (MT=3, 48 rows > 32): `done` and `err` at cycle 1; no strobes ever asserted.
- num_common=0: `err`=1; a legal `start` in the next cycle runs normally.
- `rstn` pulsed low at cycle 40 of the 8/8/16 run: all outputs 0 next cycle; a new `start` restarts from tile (0,0).
- `start` held high throughout: only one run is executed per DONE→IDLE; `perf_cycles`=153 with the PERF macro defined.
